pixel_stream_formatter: RTL and testbench
=========================================

# pixel_stream_formatter

Upstream front end of the input layer. Accepts 8-bit grayscale pixels from the outside world over a valid/ready handshake and thresholds each one to a single bit. Holds completed frames in a two-entry ping-pong bit buffer, then replays each frame as a contiguous serial burst on `pixelValue`/`inputsInbound`. The burst is timed to the input layer controller's `readyForInputs`, so the input layer can finish one image while the next is being loaded.

## Interface
- `PIXEL_COUNT`, 784: pixels per frame (28x28); index counters are 10 bits.
- `PIXEL_WIDTH`, 8: grayscale pixel width.
- `THRESHOLD`, 128: a pixel maps to bit 1 when `pixelIn >= THRESHOLD`, unsigned compare.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `resetN  in  1`: reset, asynchronous and active-low.
- `pixelIn  in  PIXEL_WIDTH`: grayscale pixel.
- `pixelValid  in  1`: `pixelIn` is valid this cycle.
- `pixelFirst  in  1`: qualifies `pixelIn` as pixel 0 of a frame; only meaningful with `pixelValid`.
- `pixelReady  out  1`: the block accepts a pixel this cycle.
- `readyForInputs  in  1`: from the input layer; it may accept a new frame.
- `inputsInbound  out  1`: a serial frame is streaming on `pixelValue`; registered.
- `pixelValue  out  1`: thresholded pixel bit, one per cycle while `inputsInbound` is high; registered.
- `syncError  out  1`: one-cycle pulse when a partial frame is discarded.
- `framesSent  out  16`: count of completed bursts; wraps from 0xFFFF to 0.

## Operation
- Storage: two `PIXEL_COUNT`-bit buffers B0/B1, plus `full[1:0]`, `fillSel`, `drainSel`, `fillIdx[9:0]`, `drainIdx[9:0]`.
- Handshake:
  - `pixelReady = !full[fillSel]`, combinational from registered state.
  - A pixel is accepted on an edge where `pixelValid && pixelReady`.
- Fill side:
  - An accepted pixel writes its bit to `buf[fillSel][fillIdx]` and increments `fillIdx`.
  - If `pixelFirst` is set, the pixel is written at index 0 and `fillIdx` becomes 1. When `fillIdx` was not 0, the partial frame is discarded and `syncError` pulses.
  - An accept with `fillIdx == PIXEL_COUNT-1` completes the frame: `full[fillSel]` is set, `fillSel` toggles, and `fillIdx` returns to 0.
  - An accepted pixel without `pixelFirst` at `fillIdx == 0` is legal and starts a frame.
- Drain FSM has three states: IDLE, STREAM, GAP.
  - IDLE -> STREAM on an edge with `full[drainSel] && readyForInputs`. That edge sets `inputsInbound` to 1, sets `pixelValue` to `buf[drainSel][0]`, and sets `drainIdx` to 1.
  - STREAM: each edge drives `pixelValue` with `buf[drainSel][drainIdx]` and increments `drainIdx`. `readyForInputs` is ignored once streaming has started, because the input layer drops it when its queue fills.
  - STREAM -> GAP on the edge after the last bit (bit index `PIXEL_COUNT-1`) has been presented. That edge clears `inputsInbound` and `pixelValue`, clears `full[drainSel]`, toggles `drainSel`, and increments `framesSent`.
  - GAP -> IDLE unconditionally after one cycle. This guarantees `inputsInbound` is low for at least one cycle between bursts.
- Frames drain strictly in fill order.
- Reset (asserted at any time, including mid-stream or mid-fill):
  - All state is cleared immediately: `full = 0`, both selectors 0, both indices 0, FSM in IDLE.
  - Output values during reset: `inputsInbound` 0, `pixelValue` 0, `syncError` 0, `framesSent` 0, `pixelReady` 1.
  - Buffer contents need not be cleared.

## Timing
- `pixelReady` may be 1 during reset. Pixels presented while reset is asserted are not accepted.
- Fill-to-stream latency: a frame's last pixel accepted on edge E with the drain FSM in IDLE and `readyForInputs` high gives `inputsInbound` = 1 after edge E+1.
- A burst is exactly `PIXEL_COUNT` consecutive cycles of `inputsInbound` = 1, with no bubbles.
- Back-to-back frames: the minimum gap between bursts is 1 cycle, and longer if `readyForInputs` is low.
- Both buffers full: `pixelReady` = 0 until the edge that clears `full[drainSel]`. That edge and a completing fill may coincide on different buffers.
- A clear of `full[x]` becomes visible in `pixelReady` on the cycle after the clearing edge. Set and clear of the same bit on the same edge cannot occur.
- `syncError` is high for exactly the cycle after the offending accept edge.

## Test plan
- Single frame: feed 784 pixels with value `i[7:0]` for pixel i, `readyForInputs`=1. Expect one 784-cycle burst beginning 1 cycle after the last accept; bit i = (`i[7:0]` >= 128); `framesSent` = 1.
- Threshold edges: pixels alternating 127/128, plus 0 and 255. Expect streamed bits 0,1 alternating; 0 -> 0; 255 -> 1.
- Ping-pong stall: hold `readyForInputs`=0 and feed 3 frames. Expect `pixelReady` to drop after 1568 accepts. Raising `readyForInputs` releases frame 1, then frame 2; `pixelReady` returns 1 the cycle after frame 1's burst ends; order preserved.
- Resync: send 300 pixels, then `pixelFirst` with a new frame of 784 pixels. Expect a one-cycle `syncError` pulse and a streamed frame that contains only the new data.
- Mid-stream reset: assert `resetN`=0 at burst cycle 400. Expect `inputsInbound` and `pixelValue` to go 0 asynchronously, `framesSent` = 0 and `pixelReady` = 1 after release, and the next full frame streams normally.
- Wrap: preload `framesSent` = 0xFFFF via hierarchical force, complete one burst. Expect `framesSent` = 0.

Source files
------------

// File: rtl/pixel_stream_formatter.sv
`default_nettype none
// ============================================================================
// Module  : pixel_stream_formatter
// Brief   : Thresholds 8-bit pixels into a ping-pong bit buffer and replays
//           each completed frame as a contiguous serial burst.
// Revision: 1.0 - initial release
// ============================================================================
module pixel_stream_formatter #(
  parameter int PIXEL_COUNT = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 128
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [PIXEL_WIDTH-1:0] pixelIn,
  input  logic                   pixelValid,
  input  logic                   pixelFirst,
  output logic                   pixelReady,
  input  logic                   readyForInputs,
  output logic                   inputsInbound,
  output logic                   pixelValue,
  output logic                   syncError,
  output logic [15:0]            framesSent
);

  localparam int IDX_W = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(PIXEL_COUNT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [PIXEL_COUNT-1:0] buf0_q, buf0_d;
  logic [PIXEL_COUNT-1:0] buf1_q, buf1_d;
  logic [1:0]             full_q, full_d;
  logic [1:0]             full_set, full_clr;
  logic                   fill_sel_q, fill_sel_d;
  logic                   drain_sel_q, drain_sel_d;
  logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
  logic [IDX_W-1:0]       drain_idx_q, drain_idx_d;
  logic [1:0]             state_q, state_d;
  logic                   inbound_q, inbound_d;
  logic                   value_q, value_d;
  logic                   sync_error_q, sync_error_d;
  logic [15:0]            frames_sent_q, frames_sent_d;

  logic                   pixel_ready;
  logic                   accept;
  logic                   pixel_bit;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_bit;

  assign pixel_ready = !full_q[fill_sel_q];
  assign accept      = pixelValid && pixel_ready;
  assign pixel_bit   = (pixelIn >= PIXEL_WIDTH'(THRESHOLD));

  // A pixelFirst always restarts the frame at index 0, discarding any partial.
  always_comb begin
    wr_idx       = pixelFirst ? '0 : fill_idx_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    fill_idx_d   = fill_idx_q;
    fill_sel_d   = fill_sel_q;
    full_set     = 2'b00;
    sync_error_d = 1'b0;
    if (accept) begin
      if (fill_sel_q) buf1_d[wr_idx] = pixel_bit;
      else            buf0_d[wr_idx] = pixel_bit;
      sync_error_d = pixelFirst && (fill_idx_q != '0);
      if (wr_idx == LAST_IDX) begin
        full_set[fill_sel_q] = 1'b1;
        fill_sel_d           = !fill_sel_q;
        fill_idx_d           = '0;
      end else begin
        fill_idx_d = wr_idx + 1'b1;
      end
    end
  end

  // drain_idx reaches END_IDX once the last bit is on the wire; clamp the read.
  always_comb begin
    rd_idx = ((state_q == S_STREAM) && (drain_idx_q != END_IDX)) ? drain_idx_q : '0;
    rd_bit = drain_sel_q ? buf1_q[rd_idx] : buf0_q[rd_idx];
  end

  always_comb begin
    state_d       = state_q;
    drain_idx_d   = drain_idx_q;
    drain_sel_d   = drain_sel_q;
    inbound_d     = inbound_q;
    value_d       = value_q;
    frames_sent_d = frames_sent_q;
    full_clr      = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (full_q[drain_sel_q] && readyForInputs) begin
          state_d     = S_STREAM;
          inbound_d   = 1'b1;
          value_d     = rd_bit;
          drain_idx_d = 10'd1;
        end
      end
      S_STREAM: begin
        if (drain_idx_q == END_IDX) begin
          state_d               = S_GAP;
          inbound_d             = 1'b0;
          value_d               = 1'b0;
          drain_idx_d           = '0;
          full_clr[drain_sel_q] = 1'b1;
          drain_sel_d           = !drain_sel_q;
          frames_sent_d         = frames_sent_q + 16'd1;
        end else begin
          value_d     = rd_bit;
          drain_idx_d = drain_idx_q + 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign full_d = (full_q & ~full_clr) | full_set;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full_q        <= 2'b00;
      fill_sel_q    <= 1'b0;
      drain_sel_q   <= 1'b0;
      fill_idx_q    <= '0;
      drain_idx_q   <= '0;
      state_q       <= S_IDLE;
      inbound_q     <= 1'b0;
      value_q       <= 1'b0;
      sync_error_q  <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      full_q        <= full_d;
      fill_sel_q    <= fill_sel_d;
      drain_sel_q   <= drain_sel_d;
      fill_idx_q    <= fill_idx_d;
      drain_idx_q   <= drain_idx_d;
      state_q       <= state_d;
      inbound_q     <= inbound_d;
      value_q       <= value_d;
      sync_error_q  <= sync_error_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  // Frame storage carries no reset; validity is tracked by full_q alone.
  always_ff @(posedge clk) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  assign pixelReady    = pixel_ready;
  assign inputsInbound = inbound_q;
  assign pixelValue    = value_q;
  assign syncError     = sync_error_q;
  assign framesSent    = frames_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_formatter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_stream_formatter
// Brief   : Randomized bench for pixel_stream_formatter with a frame-queue
//           reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pixel_stream_formatter;

  localparam int PC  = 784;
  localparam int THR = 128;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [7:0]  pixelIn = 8'd0;
  logic        pixelValid = 1'b0;
  logic        pixelFirst = 1'b0;
  logic        pixelReady;
  logic        readyForInputs = 1'b1;
  logic        inputsInbound;
  logic        pixelValue;
  logic        syncError;
  logic [15:0] framesSent;

  pixel_stream_formatter #(.PIXEL_COUNT(PC), .PIXEL_WIDTH(8), .THRESHOLD(THR)) dut (
    .clk(clk), .resetN(resetN), .pixelIn(pixelIn), .pixelValid(pixelValid),
    .pixelFirst(pixelFirst), .pixelReady(pixelReady), .readyForInputs(readyForInputs),
    .inputsInbound(inputsInbound), .pixelValue(pixelValue), .syncError(syncError),
    .framesSent(framesSent)
  );

  always #5 clk = ~clk;

  // Reference: completed frames awaiting (or in) their burst, plus the partial frame.
  logic [PC-1:0] exp_frames[$];
  logic [PC-1:0] part;
  logic [PC-1:0] burst;
  int            part_len = 0;
  int            burst_len = 0;
  int            cyc = 0;
  logic          exp_sync = 1'b0;
  logic [15:0]   exp_sent = 16'd0;
  bit            rand_rdy = 1'b0;
  int            sync_seen = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic v, input logic first, input logic [7:0] px, output bit acc);
    logic [PC-1:0] ef;
    @(negedge clk);
    cyc++;
    if (inputsInbound) begin
      if (burst_len < PC) burst[burst_len] = pixelValue;
      burst_len++;
    end else if (burst_len > 0) begin
      check("burst_len", burst_len, PC);
      check("gap_value", pixelValue, 1'b0);
      if (exp_frames.size() == 0) begin
        check("unexpected_burst", 1'b1, 1'b0);
      end else begin
        ef = exp_frames.pop_front();
        check("frame_bit_errors", $countones(ef ^ burst), 0);
      end
      exp_sent = exp_sent + 16'd1;
      check("frames_sent", framesSent, exp_sent);
      burst_len = 0;
    end
    check("sync_error", syncError, exp_sync);
    if (syncError) sync_seen++;
    check("pixel_ready", pixelReady, exp_frames.size() < 2);

    pixelValid = v;
    pixelFirst = first;
    pixelIn    = px;
    if (rand_rdy) readyForInputs = 1'($urandom_range(0, 1));
    acc      = v && (exp_frames.size() < 2);
    exp_sync = 1'b0;
    if (acc) begin
      if (first) begin
        exp_sync = (part_len != 0);
        part_len = 0;
      end
      part[part_len] = (px >= THR);
      part_len++;
      if (part_len == PC) begin
        exp_frames.push_back(part);
        part_len = 0;
      end
    end
  endtask

  task automatic send_pixel(input logic [7:0] px, input logic first, input bit gaps);
    bit acc;
    int n;
    if (gaps && $urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 8'd0, acc);
    n = 0;
    do begin
      tick(1'b1, first, px, acc);
      n++;
    end while (!acc && n < 4000);
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  // mode 0: ramp, 1: threshold edges, 2: random
  task automatic send_frame(input int mode, input bit with_first);
    logic [7:0] px;
    for (int i = 0; i < PC; i++) begin
      case (mode)
        0:       px = 8'(i);
        1:       px = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : (i % 2 == 1) ? 8'd128 : 8'd127;
        default: px = 8'($urandom_range(0, 255));
      endcase
      send_pixel(px, with_first && (i == 0), mode == 2);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, acc);
  endtask

  task automatic wait_drain();
    bit acc;
    int n = 0;
    while ((exp_frames.size() != 0 || burst_len != 0) && n < 8000) begin
      tick(1'b0, 1'b0, 8'd0, acc);
      n++;
    end
    if (n >= 8000) check("drain_timeout", 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    bit acc;
    int t0;
    int s0;

    // Reset state, with a pixel offered that must not be taken.
    pixelValid = 1'b1;
    pixelIn    = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_inbound", inputsInbound, 1'b0);
    check("rst_value", pixelValue, 1'b0);
    check("rst_sync", syncError, 1'b0);
    check("rst_sent", framesSent, 16'd0);
    check("rst_ready", pixelReady, 1'b1);
    pixelValid = 1'b0;
    resetN     = 1'b1;

    // Single ramp frame and fill-to-stream latency.
    readyForInputs = 1'b1;
    send_frame(0, 1'b0);
    t0 = cyc;
    while (!inputsInbound && (cyc - t0) < 20) tick(1'b0, 1'b0, 8'd0, acc);
    check("latency", cyc - t0, 2);
    wait_drain();
    check("single_sent", framesSent, 16'd1);

    // Threshold edges.
    send_frame(1, 1'b1);
    wait_drain();

    // Ping-pong stall: two frames fill both buffers, third waits.
    readyForInputs = 1'b0;
    send_frame(2, 1'b0);
    send_frame(2, 1'b0);
    idle(1);
    check("stall_ready", pixelReady, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'd200, acc);
    readyForInputs = 1'b1;
    send_frame(2, 1'b0);
    wait_drain();
    check("stall_sent", framesSent, exp_sent);

    // Resync: partial frame abandoned by pixelFirst.
    s0 = sync_seen;
    for (int i = 0; i < 300; i++) send_pixel(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_frame(2, 1'b1);
    wait_drain();
    check("resync_pulses", sync_seen - s0, 1);

    // Mid-stream reset at burst cycle 400.
    send_frame(2, 1'b0);
    t0 = cyc;
    while (burst_len < 400 && (cyc - t0) < 4000) tick(1'b0, 1'b0, 8'd0, acc);
    check("reached_400", burst_len, 400);
    #2 resetN = 1'b0;
    #1;
    check("async_inbound", inputsInbound, 1'b0);
    check("async_value", pixelValue, 1'b0);
    check("async_sent", framesSent, 16'd0);
    exp_frames.delete();
    part_len  = 0;
    burst_len = 0;
    exp_sync  = 1'b0;
    exp_sent  = 16'd0;
    pixelValid = 1'b1;
    pixelIn    = 8'd255;
    repeat (2) @(negedge clk);
    pixelValid = 1'b0;
    resetN     = 1'b1;
    check("post_rst_ready", pixelReady, 1'b1);
    check("post_rst_sent", framesSent, 16'd0);
    send_frame(2, 1'b0);
    wait_drain();
    check("post_rst_count", framesSent, 16'd1);

    // framesSent wrap.
    force dut.frames_sent_q = 16'hFFFF;
    idle(1);
    release dut.frames_sent_q;
    exp_sent = 16'hFFFF;
    send_frame(0, 1'b0);
    wait_drain();
    check("wrap", framesSent, 16'd0);

    // Random traffic with a toggling readyForInputs.
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(2, 1'($urandom_range(0, 1)));
    rand_rdy = 1'b0;
    readyForInputs = 1'b1;
    wait_drain();
    check("final_sent", framesSent, exp_sent);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
